dht_read_scheduler: RTL and testbench

Round-robin scheduler that shares the single DHT11 reader among up to N_REQ requesters, such as the UART command path and periodic monitors. It grants one requester at a time and drives the reader's start/reset line. It enforces a timeout on each read and a minimum idle gap between reads, as the DHT11 requires. It returns the 32-bit reading and a status to the granted requester. It sits between the requesters and the `dht11` instance, replacing the direct `fpga_core`→`dht11` start connection.

---
 rtl/dht_read_scheduler.sv | 179 +++++++++++++++++
 tb/tb_dht_read_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dht_read_scheduler.sv
// dht_read_scheduler
// Shares one DHT11 reader among N_REQ requesters using round-robin arbitration.
// A granted requester gets one read. The reader is released from reset only
// while a read is in flight. Each read is bounded by a timeout and is followed
// by a forced idle gap, because the sensor needs recovery time between reads.
//
// Ports:
//   i_Clock      system clock; all logic runs on the rising edge
//   i_Reset      synchronous, active-high reset
//   i_Req        per-requester level request, held until its o_Ack
//   o_Ack        one-hot, single-cycle completion pulse to the served requester
//   o_Data       last successful reading (valid with o_Ack when o_Error=0)
//   o_Error      read failed (sensor error or timeout), qualified by o_Ack
//   o_Timeout    failure was a timeout, qualified by o_Ack
//   o_Grant_Id   index of the requester currently or last granted
//   o_Busy       high whenever the scheduler is not in IDLE
//   o_Dth_Start  reader rst_n; high only while waiting on a read
//   i_Dth_Data   reader data word
//   i_Dth_Done   reader completion flag (level)
//   i_Dth_Error  reader error flag (level)
module dht_read_scheduler #(
  parameter int N_REQ          = 4,
  parameter int MIN_GAP_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  localparam int ID_W          = $clog2(N_REQ)
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic [N_REQ-1:0]  i_Req,
  output logic [N_REQ-1:0]  o_Ack,
  output logic [31:0]       o_Data,
  output logic              o_Error,
  output logic              o_Timeout,
  output logic [ID_W-1:0]   o_Grant_Id,
  output logic              o_Busy,
  output logic              o_Dth_Start,
  input  logic [31:0]       i_Dth_Data,
  input  logic              i_Dth_Done,
  input  logic              i_Dth_Error
);

  localparam int CNT_MAXV = (MIN_GAP_CYCLES > TIMEOUT_CYCLES) ? MIN_GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAXV + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(MIN_GAP_CYCLES);
  localparam logic [CNT_W-1:0] TO_LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  // The reader raises stale flags while it leaves reset; the first two
  // WAIT cycles (counter values 0 and 1) are not trusted.
  localparam logic [CNT_W-1:0] MASK_CYCLES = CNT_W'(2);
  localparam logic [ID_W-1:0]  ID_ONE      = ID_W'(1);
  localparam logic [N_REQ-1:0] ACK_ONE     = N_REQ'(1);

  typedef enum logic [1:0] {
    ST_GAP  = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   gapCount_r;
  logic [CNT_W-1:0]   timeoutCount_r;
  logic [ID_W-1:0]    rrPtr_r;          // where the next search starts

  logic               reqFound_s;
  logic [ID_W-1:0]    reqPick_s;
  logic [ID_W-1:0]    searchIdx_s;
  logic               searchHit_s;
  logic [CNT_W-1:0]   timeoutNext_s;
  logic               flagsLive_s;
  logic [N_REQ-1:0]   ackOneHot_s;

  // Round-robin search: first pending request at or above the pointer, wrapping
  always_comb begin
    reqFound_s  = 1'b0;
    reqPick_s   = rrPtr_r;
    searchIdx_s = rrPtr_r;
    searchHit_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      searchIdx_s = rrPtr_r + ID_W'(i);  // wraps naturally since N_REQ is a power of two
      searchHit_s = !reqFound_s && i_Req[searchIdx_s];
      reqPick_s   = searchHit_s ? searchIdx_s : reqPick_s;
      reqFound_s  = reqFound_s | searchHit_s;
    end
  end

  // Saturating timeout increment, flag-mask qualifier and ack one-hot decode
  always_comb begin
    timeoutNext_s = (timeoutCount_r == CNT_SAT) ? timeoutCount_r : (timeoutCount_r + CNT_ONE);
    flagsLive_s   = (timeoutCount_r >= MASK_CYCLES);
    ackOneHot_s   = ACK_ONE << o_Grant_Id;
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r        <= ST_GAP;
      gapCount_r     <= GAP_LOAD;
      timeoutCount_r <= '0;
      rrPtr_r        <= '0;
      o_Ack          <= '0;
      o_Data         <= 32'h0000_0000;
      o_Error        <= 1'b0;
      o_Timeout      <= 1'b0;
      o_Grant_Id     <= '0;
      o_Dth_Start    <= 1'b0;
      o_Busy         <= 1'b1;
    end else begin
      o_Ack <= '0;
      case (state_r)
        ST_GAP: begin
          // Leaving on the last counted cycle makes GAP exactly MIN_GAP_CYCLES long
          if (gapCount_r <= CNT_ONE) begin
            gapCount_r <= '0;
            state_r    <= ST_IDLE;
            o_Busy     <= 1'b0;
          end else begin
            gapCount_r <= gapCount_r - CNT_ONE;
          end
        end

        ST_IDLE: begin
          if (reqFound_s) begin
            o_Grant_Id     <= reqPick_s;
            rrPtr_r        <= reqPick_s + ID_ONE;
            timeoutCount_r <= '0;
            o_Dth_Start    <= 1'b1;
            o_Busy         <= 1'b1;
            state_r        <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          timeoutCount_r <= timeoutNext_s;
          // Error has priority over done; timeout only when no flag qualifies
          if (flagsLive_s && i_Dth_Error) begin
            o_Error     <= 1'b1;
            o_Timeout   <= 1'b0;
            o_Ack       <= ackOneHot_s;
            o_Dth_Start <= 1'b0;
            state_r     <= ST_DONE;
          end else if (flagsLive_s && i_Dth_Done) begin
            o_Data      <= i_Dth_Data;
            o_Error     <= 1'b0;
            o_Timeout   <= 1'b0;
            o_Ack       <= ackOneHot_s;
            o_Dth_Start <= 1'b0;
            state_r     <= ST_DONE;
          end else if (timeoutNext_s >= TO_LIMIT) begin
            o_Error     <= 1'b1;
            o_Timeout   <= 1'b1;
            o_Ack       <= ackOneHot_s;
            o_Dth_Start <= 1'b0;
            state_r     <= ST_DONE;
          end
        end

        ST_DONE: begin
          o_Error    <= 1'b0;
          o_Timeout  <= 1'b0;
          gapCount_r <= GAP_LOAD;
          state_r    <= ST_GAP;
        end

        default: begin
          o_Error     <= 1'b0;
          o_Timeout   <= 1'b0;
          o_Dth_Start <= 1'b0;
          o_Busy      <= 1'b1;
          gapCount_r  <= GAP_LOAD;
          state_r     <= ST_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht_read_scheduler.sv
// tb_dht_read_scheduler
// Directed bench for dht_read_scheduler with N_REQ=4, MIN_GAP_CYCLES=16,
// TIMEOUT_CYCLES=64. Outputs are sampled on the falling clock edge and inputs
// are driven there too, so every value is settled away from the active edge.
module tb_dht_read_scheduler;

  logic        i_Clock;
  logic        i_Reset;
  logic [3:0]  i_Req;
  logic [3:0]  o_Ack;
  logic [31:0] o_Data;
  logic        o_Error;
  logic        o_Timeout;
  logic [1:0]  o_Grant_Id;
  logic        o_Busy;
  logic        o_Dth_Start;
  logic [31:0] i_Dth_Data;
  logic        i_Dth_Done;
  logic        i_Dth_Error;

  int compared   = 0;
  int mismatched = 0;

  dht_read_scheduler #(
    .N_REQ          (4),
    .MIN_GAP_CYCLES (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Req       (i_Req),
    .o_Ack       (o_Ack),
    .o_Data      (o_Data),
    .o_Error     (o_Error),
    .o_Timeout   (o_Timeout),
    .o_Grant_Id  (o_Grant_Id),
    .o_Busy      (o_Busy),
    .o_Dth_Start (o_Dth_Start),
    .i_Dth_Data  (i_Dth_Data),
    .i_Dth_Done  (i_Dth_Done),
    .i_Dth_Error (i_Dth_Error)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance falling edges until o_Dth_Start is seen, bounded; n = edges waited
  task automatic waitStart(input string tag, output int n);
    n = 0;
    while (!o_Dth_Start && n < 200) begin
      @(negedge i_Clock);
      n++;
    end
    chk({tag, "_seen"}, 32'(o_Dth_Start), 32'd1);
  endtask

  int n;
  int busyCycles;
  int highs;
  int earlyAcks;
  int waitCycles;
  logic startSeen;

  initial begin
    i_Reset     = 1'b1;
    i_Req       = 4'b0000;
    i_Dth_Data  = 32'h0000_0000;
    i_Dth_Done  = 1'b0;
    i_Dth_Error = 1'b0;
    repeat (3) @(negedge i_Clock);
    i_Reset = 1'b0;

    // ---- 1: reset values, 16 busy GAP cycles, reader held in reset
    chk("rst_ack",     32'(o_Ack),       32'h0);
    chk("rst_data",    o_Data,           32'h0);
    chk("rst_error",   32'(o_Error),     32'h0);
    chk("rst_timeout", 32'(o_Timeout),   32'h0);
    chk("rst_grant",   32'(o_Grant_Id),  32'h0);
    chk("rst_start",   32'(o_Dth_Start), 32'h0);
    chk("rst_busy",    32'(o_Busy),      32'h1);
    busyCycles = 0;
    startSeen  = 1'b0;
    while (o_Busy && busyCycles < 40) begin
      busyCycles++;
      startSeen = startSeen | o_Dth_Start;
      @(negedge i_Clock);
    end
    chk("gap_busy_cycles", 32'(busyCycles), 32'd16);
    chk("gap_start_low",   32'(startSeen),  32'd0);

    // ---- 2: single request on requester 2, reader done 10 cycles after start
    i_Req = 4'b0100;
    waitStart("t2_start", n);
    chk("t2_first_start_lat", 32'(busyCycles + n), 32'd17);
    chk("t2_grant", 32'(o_Grant_Id), 32'd2);
    chk("t2_busy",  32'(o_Busy),     32'd1);
    highs     = 0;
    earlyAcks = 0;
    for (int k = 1; k <= 11; k++) begin
      highs     += int'(o_Dth_Start);
      earlyAcks += int'(o_Ack != 4'b0000);
      if (k == 11) begin
        i_Dth_Data = 32'h3200_1A00;
        i_Dth_Done = 1'b1;
      end
      @(negedge i_Clock);
    end
    chk("t2_start_high_cycles", 32'(highs),     32'd11);
    chk("t2_no_early_ack",      32'(earlyAcks), 32'd0);
    chk("t2_ack",     32'(o_Ack),       32'h4);
    chk("t2_data",    o_Data,           32'h3200_1A00);
    chk("t2_error",   32'(o_Error),     32'd0);
    chk("t2_timeout", 32'(o_Timeout),   32'd0);
    chk("t2_start_done", 32'(o_Dth_Start), 32'd0);
    i_Dth_Done = 1'b0;
    i_Req      = 4'b0000;
    @(negedge i_Clock);
    chk("t2_ack_single", 32'(o_Ack), 32'h0);

    // ---- 3: reset, then all four requesters held; order 0,1,2,3,0
    i_Reset = 1'b1;
    @(negedge i_Clock);
    i_Reset = 1'b0;
    i_Req   = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      waitStart("t3_start", n);
      if (r == 0) chk("t3_first_lat", 32'(n), 32'd17);
      else        chk("t3_ack_to_start", 32'(n), 32'd18);
      chk("t3_grant", 32'(o_Grant_Id), 32'(r % 4));
      repeat (2) @(negedge i_Clock);
      i_Dth_Data = 32'hA000_0000 + 32'(r);
      i_Dth_Done = 1'b1;
      @(negedge i_Clock);
      chk("t3_ack",  32'(o_Ack), 32'h1 << (r % 4));
      chk("t3_data", o_Data,     32'hA000_0000 + 32'(r));
      i_Dth_Done = 1'b0;
      if (r == 4) i_Req = 4'b0001;
    end

    // ---- 4: requester 0, silent reader -> timeout after 64 WAIT cycles
    waitStart("t4_start", n);
    chk("t4_ack_to_start", 32'(n), 32'd18);
    chk("t4_grant", 32'(o_Grant_Id), 32'd0);
    waitCycles = 0;
    while (o_Ack == 4'b0000 && waitCycles < 200) begin
      @(negedge i_Clock);
      waitCycles++;
    end
    chk("t4_wait_cycles", 32'(waitCycles),  32'd64);
    chk("t4_ack",         32'(o_Ack),       32'h1);
    chk("t4_error",       32'(o_Error),     32'd1);
    chk("t4_timeout",     32'(o_Timeout),   32'd1);
    chk("t4_data_kept",   o_Data,           32'hA000_0004);
    chk("t4_start_done",  32'(o_Dth_Start), 32'd0);
    i_Req = 4'b0010;

    // ---- 5: stale done masked in first WAIT cycles; done+error together -> error
    waitStart("t5_start", n);
    chk("t5_ack_to_start", 32'(n), 32'd18);
    chk("t5_grant", 32'(o_Grant_Id), 32'd1);
    i_Dth_Data = 32'hDEAD_BEEF;
    i_Dth_Done = 1'b1;
    @(negedge i_Clock);
    chk("t5_mask_c2", 32'(o_Ack), 32'h0);
    @(negedge i_Clock);
    chk("t5_mask_c3", 32'(o_Ack), 32'h0);
    i_Dth_Done = 1'b0;
    repeat (2) @(negedge i_Clock);
    i_Dth_Done  = 1'b1;
    i_Dth_Error = 1'b1;
    @(negedge i_Clock);
    chk("t5_ack",        32'(o_Ack),       32'h2);
    chk("t5_error",      32'(o_Error),     32'd1);
    chk("t5_timeout",    32'(o_Timeout),   32'd0);
    chk("t5_data_kept",  o_Data,           32'hA000_0004);
    chk("t5_start_done", 32'(o_Dth_Start), 32'd0);
    i_Dth_Done  = 1'b0;
    i_Dth_Error = 1'b0;
    i_Req       = 4'b1000;

    // ---- 6: reset 5 cycles into WAIT drops the read; request re-granted
    waitStart("t6_start", n);
    chk("t6_ack_to_start", 32'(n), 32'd18);
    chk("t6_grant", 32'(o_Grant_Id), 32'd3);
    repeat (4) @(negedge i_Clock);
    i_Reset = 1'b1;
    @(negedge i_Clock);
    i_Reset = 1'b0;
    chk("t6_rst_start", 32'(o_Dth_Start), 32'd0);
    chk("t6_rst_ack",   32'(o_Ack),       32'h0);
    chk("t6_rst_data",  o_Data,           32'h0);
    chk("t6_rst_busy",  32'(o_Busy),      32'd1);
    chk("t6_rst_grant", 32'(o_Grant_Id),  32'd0);
    waitStart("t6_regrant", n);
    chk("t6_regrant_lat", 32'(n), 32'd17);
    chk("t6_regrant_id",  32'(o_Grant_Id), 32'd3);
    repeat (2) @(negedge i_Clock);
    i_Dth_Data = 32'h1122_3344;
    i_Dth_Done = 1'b1;
    @(negedge i_Clock);
    chk("t6_ack",  32'(o_Ack), 32'h8);
    chk("t6_data", o_Data,     32'h1122_3344);
    i_Dth_Done = 1'b0;
    i_Req      = 4'b0000;
    @(negedge i_Clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
